// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame timing
// that the PISO transmitter and this receiver both build from.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    function automatic logic is_busy(input rx_state_e state);
        return (state != ST_IDLE);
    endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Receiver-side bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_sipo_if import uart_pkg::*; #(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic                 SERIAL_IN;
    logic [DATA_BITS-1:0] DATA_OUT;
    logic                 DATA_VALID;
    logic                 FRAME_ERR;
    logic                 BUSY;

    modport slave (
        input  SERIAL_IN,
        output DATA_OUT,
        output DATA_VALID,
        output FRAME_ERR,
        output BUSY
    );

    modport master (
        output SERIAL_IN,
        input  DATA_OUT,
        input  DATA_VALID,
        input  FRAME_ERR,
        input  BUSY
    );

endinterface

// File: rtl/uart_rx_sipo_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; synchronous reset loads RESET_VAL
// so an idle-high line does not look like activity coming out of reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: mid-bit sampling of start/data/stop, LSB-first byte recovery,
// one-cycle DATA_VALID or FRAME_ERR strobe per frame.
module uart_rx_sipo import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic          CLK,
    input  logic          CLR,
    uart_rx_sipo_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rxs_s;
    rx_state_e            state_r;
    rx_state_e            state_next_s;
    logic [CNT_W-1:0]     clk_cnt_r;
    logic [CNT_W-1:0]     clk_cnt_next_s;
    logic [BIT_W-1:0]     bit_idx_r;
    logic [BIT_W-1:0]     bit_idx_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_next_s;
    logic                 valid_r;
    logic                 valid_next_s;
    logic                 ferr_r;
    logic                 ferr_next_s;
    logic                 busy_r;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk  (CLK),
        .srst (CLR),
        .d    (bus.SERIAL_IN),
        .q    (rxs_s)
    );

    // next-state, counter, shift-register and strobe decode
    always_comb begin
        state_next_s   = state_r;
        clk_cnt_next_s = clk_cnt_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        data_next_s    = data_r;
        valid_next_s   = 1'b0;
        ferr_next_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_next_s   = ST_START;
                    clk_cnt_next_s = CNT_ZERO;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end

            // a start bit that is no longer low at its midpoint was a glitch
            ST_START: begin
                if (clk_cnt_r == CNT_HALF) begin
                    clk_cnt_next_s = CNT_ZERO;
                    bit_idx_next_s = BIT_ZERO;
                    if (!rxs_s) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_ONE;
                end
            end

            // shifting in at the MSB leaves the first received bit at bit 0
            ST_DATA: begin
                if (clk_cnt_r == CNT_FULL) begin
                    clk_cnt_next_s = CNT_ZERO;
                    shift_next_s   = {rxs_s, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_next_s = BIT_ZERO;
                        state_next_s   = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + BIT_ONE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (clk_cnt_r == CNT_FULL) begin
                    clk_cnt_next_s = CNT_ZERO;
                    if (rxs_s) begin
                        data_next_s  = shift_r;
                        valid_next_s = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        ferr_next_s  = 1'b1;
                        state_next_s = ST_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_ONE;
                end
            end

            // a held-low line (break) must return high before a new start is accepted
            ST_WAIT_HIGH: begin
                if (rxs_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HIGH;
                end
            end

            default: begin
                state_next_s   = ST_IDLE;
                clk_cnt_next_s = CNT_ZERO;
                bit_idx_next_s = BIT_ZERO;
            end
        endcase
    end

    // state and output registers; CLR overrides everything including mid-frame
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= CNT_ZERO;
            bit_idx_r <= BIT_ZERO;
            shift_r   <= {DATA_BITS{1'b0}};
            data_r    <= {DATA_BITS{1'b0}};
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            clk_cnt_r <= clk_cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            data_r    <= data_next_s;
            valid_r   <= valid_next_s;
            ferr_r    <= ferr_next_s;
            busy_r    <= is_busy(state_next_s);
        end
    end

    assign bus.DATA_OUT   = data_r;
    assign bus.DATA_VALID = valid_r;
    assign bus.FRAME_ERR  = ferr_r;
    assign bus.BUSY       = busy_r;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Bench for uart_rx_sipo: frame table, hand-built corner sequences and random
// frames, checked against strobe timing/data predicted from the frame format.
module tb_uart_rx_sipo;

    localparam int CPB = 16;
    localparam int DB  = 8;
    // input edge -> 2 sync flops -> half start bit -> DB data bits + stop bit
    localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    uart_rx_sipo_if #(.DATA_BITS(DB)) rx_if();

    uart_rx_sipo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (rx_if)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    typedef struct {
        int         cyc;
        int         kind;        // 1 = DATA_VALID, 2 = FRAME_ERR, 3 = both
        logic [7:0] data;
        bit         long_pulse;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         gap;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    // strobe monitor, sampled on the falling edge
    initial begin
        bit  prev;
        ev_t ev;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (rx_if.DATA_VALID === 1'b1 || rx_if.FRAME_ERR === 1'b1) begin
                ev.cyc        = cyc;
                ev.kind       = (rx_if.FRAME_ERR === 1'b1 ? 2 : 0) + (rx_if.DATA_VALID === 1'b1 ? 1 : 0);
                ev.data       = rx_if.DATA_OUT;
                ev.long_pulse = prev;
                obs_q.push_back(ev);
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int s, input int kind, input logic [7:0] d);
        ev_t e;
        e = '{cyc: s + LAT, kind: kind, data: d, long_pulse: 1'b0};
        exp_q.push_back(e);
    endfunction

    task automatic drive_level(input logic b, input int n);
        rx_if.SERIAL_IN = b;
        repeat (n) @(negedge CLK);
    endtask

    // s = index of the first rising edge that sees the start bit on the pin
    task automatic send_frame(input logic [7:0] d, input logic stop, output int s);
        s = cyc + 1;
        drive_level(1'b0, CPB);
        chk("busy_in_frame", 32'(rx_if.BUSY), 32'd1);
        for (int i = 0; i < DB; i++) begin
            drive_level(d[i], CPB);
        end
        drive_level(stop, CPB);
    endtask

    task automatic check_events();
        int n;
        chk("event_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("strobe_cycle", 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
            chk("strobe_kind", 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            chk("data_out", 32'(obs_q[i].data), 32'(exp_q[i].data));
            chk("strobe_width", 32'(obs_q[i].long_pulse), 32'(exp_q[i].long_pulse));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       tbl[9];
        int         s;
        logic [7:0] ab;
        logic [7:0] d;
        logic       stop;
        int         r;

        tbl[0] = '{8'h0B, 1'b1, 0,   20, 1, 8'h0B};
        tbl[1] = '{8'h00, 1'b1, 0,   0,  1, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 0,   0,  1, 8'hFF};
        tbl[3] = '{8'hA5, 1'b1, 0,   20, 1, 8'hA5};
        tbl[4] = '{8'h3C, 1'b1, 0,   20, 1, 8'h3C};
        tbl[5] = '{8'h5A, 1'b0, 640, 16, 2, 8'h3C};
        tbl[6] = '{8'h81, 1'b1, 0,   20, 1, 8'h81};
        tbl[7] = '{8'h0B, 1'b1, 0,   0,  1, 8'h0B};
        tbl[8] = '{8'h0B, 1'b1, 0,   20, 1, 8'h0B};

        rx_if.SERIAL_IN = 1'b1;
        CLR = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_data_out", 32'(rx_if.DATA_OUT), 32'h0);
        chk("reset_valid", 32'(rx_if.DATA_VALID), 32'h0);
        chk("reset_ferr", 32'(rx_if.FRAME_ERR), 32'h0);
        chk("reset_busy", 32'(rx_if.BUSY), 32'h0);
        CLR = 1'b0;
        drive_level(1'b1, 20);
        chk("idle_busy", 32'(rx_if.BUSY), 32'h0);

        // short low pulse: receiver starts, rejects at the start midpoint
        drive_level(1'b0, 4);
        chk("glitch_busy", 32'(rx_if.BUSY), 32'h1);
        drive_level(1'b1, 12);
        chk("glitch_idle", 32'(rx_if.BUSY), 32'h0);
        check_events();

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, s);
            expect_ev(s, tbl[i].exp_kind, tbl[i].exp_data);
            if (tbl[i].exp_kind == 1) begin
                last_good = tbl[i].exp_data;
            end
            if (tbl[i].low_after > 0) begin
                drive_level(1'b0, tbl[i].low_after);
            end
            drive_level(1'b1, tbl[i].gap);
            check_events();
        end

        // CLR pulse in the middle of data bit 4
        ab = 8'h96;
        drive_level(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            drive_level(ab[i], CPB);
        end
        drive_level(ab[4], CPB / 2);
        rx_if.SERIAL_IN = 1'b1;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("midreset_data_out", 32'(rx_if.DATA_OUT), 32'h0);
        chk("midreset_valid", 32'(rx_if.DATA_VALID), 32'h0);
        chk("midreset_ferr", 32'(rx_if.FRAME_ERR), 32'h0);
        chk("midreset_busy", 32'(rx_if.BUSY), 32'h0);
        last_good = 8'h00;
        drive_level(1'b1, 40);
        check_events();
        send_frame(8'hC3, 1'b1, s);
        expect_ev(s, 1, 8'hC3);
        last_good = 8'hC3;
        drive_level(1'b1, 10);
        check_events();

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive_level(1'b0, $urandom_range(1, 6));
                drive_level(1'b1, 12);
            end else begin
                d    = 8'($urandom);
                stop = (r != 1);
                send_frame(d, stop, s);
                if (stop) begin
                    expect_ev(s, 1, d);
                    last_good = d;
                    drive_level(1'b1, $urandom_range(0, 12));
                end else begin
                    expect_ev(s, 2, last_good);
                    drive_level(1'b1, $urandom_range(2, 12));
                end
            end
            check_events();
        end

        drive_level(1'b1, 20);
        check_events();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Serial-in/parallel-out UART receiver, the downstream stage of the PISO transmitter. It takes the transmitter's SERIAL_OUT line and recovers 8-bit frames: start bit (0), data LSB-first, stop bit (1). It samples each bit at its midpoint using a per-bit clock counter. Each complete frame produces a parallel byte with a one-cycle valid strobe, or a framing-error strobe.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit; must be even and >= 4
DATA_BITS, 8, data bits per frame; range 5..8

Ports:
CLK  input  1  system clock; all logic on rising edge
CLR  input  1  synchronous active-high reset
SERIAL_IN  input  1  asynchronous serial line, idles high
DATA_OUT  output  DATA_BITS  last correctly framed byte, bit 0 = first received
DATA_VALID  output  1  one-cycle pulse when DATA_OUT is updated
FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low
BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset (CLR high at a CLK edge):
  - state = IDLE; DATA_OUT = 0; DATA_VALID = 0; FRAME_ERR = 0; BUSY = 0.
  - Synchronizer flops = 1; bit counter and clock counter = 0.
  - CLR has priority over all other activity, including mid-frame. No partial byte is ever output.
- Input synchronization:
  - SERIAL_IN passes through a 2-flop synchronizer; RXS denotes the second flop.
  - All decisions use RXS. This adds a fixed 2-cycle latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - RXS == 0 -> START; clock counter = 0.
- START:
  - Count to CLKS_PER_BIT/2 - 1, then sample RXS.
  - Sample 0 -> DATA; clock counter = 0; bit index = 0.
  - Sample 1 -> IDLE. This is a glitch reject with no strobe.
- DATA:
  - Each time the clock counter reaches CLKS_PER_BIT - 1, sample RXS into shift-register position bit index; counter wraps to 0.
  - After sampling bit index DATA_BITS - 1 -> STOP.
  - Samples land CLKS_PER_BIT apart, mid-bit.
- STOP:
  - When the counter reaches CLKS_PER_BIT - 1, sample RXS.
  - Sample 1: DATA_OUT <= shift register; DATA_VALID = 1 for exactly the next cycle; -> IDLE.
  - Sample 0: FRAME_ERR = 1 for exactly the next cycle; DATA_OUT unchanged; -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until RXS == 1, then -> IDLE.
  - A line held low (break) therefore never produces a false frame.
- Latency:
  - Let t0 be the cycle IDLE sees RXS == 0.
  - Stop sample at t0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
  - Strobe one cycle after the stop sample.
- Back-to-back frames:
  - Returning to IDLE at the stop-bit midpoint leaves half a bit period, so a start bit immediately after the stop bit is detected.
  - No idle gap is required between frames.
- Strobe exclusivity: DATA_VALID and FRAME_ERR are never high together; neither is ever high for more than one cycle.
- Counter widths:
  - Clock counter: $clog2(CLKS_PER_BIT).
  - Bit index: $clog2(DATA_BITS) + 1.
  - No wrap beyond the terminal counts.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants for IDLE/START/DATA/STOP/WAIT_HIGH.
  - Default CLKS_PER_BIT and DATA_BITS, shared with the PISO/baud logic so TX and RX agree.
- One natural sub-module, sync_2ff: 2-flop synchronizer with a synchronous reset value of 1. It is reused for other asynchronous inputs.
- The FSM, counters and shift register stay in uart_rx_sipo.

Test Plan:
- Frame 0x0B (start 0, bits 1,1,0,1,0,0,0,0, stop 1) at CLKS_PER_BIT=16 -> DATA_OUT=0x0B, DATA_VALID high exactly 1 cycle at the computed latency, FRAME_ERR stays 0.
- Back-to-back frames 0x00, 0xFF, 0xA5 with no idle gap -> three DATA_VALID pulses with DATA_OUT 0x00, 0xFF, 0xA5 in order, exactly 160 cycles apart.
- Glitch: SERIAL_IN low for 4 cycles, then high -> returns to IDLE, BUSY drops, no strobe; a following 0x3C frame is received correctly.
- Framing error: frame 0x5A with stop bit 0, line held low for 40 bit times, then high, then frame 0x81 -> one FRAME_ERR pulse, DATA_OUT keeps its prior value, no frame during the low period, then DATA_OUT=0x81 with DATA_VALID.
- Reset mid-frame: CLR high for 1 cycle during data bit 4 -> all outputs 0 the next cycle, state IDLE, no strobe; a subsequent 0xC3 frame decodes correctly.
- Transmitter loopback: drive D7..D0 = 0x0B into the PISO with matching bit timing, connect SERIAL_OUT to SERIAL_IN -> DATA_OUT=0x0B once per frame.
